// File: rtl/shift_add_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier_seq
// Description : Iterative unsigned shift-and-add multiplier, one partial
//               product per clock, with a single-cycle done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier_seq #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset_asynchronous_n,
    input  logic             start,
    input  logic [W-1:0]     operand_a,
    input  logic [W-1:0]     operand_b,
    output logic [2*W-1:0]   product,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [2*W-1:0]     r_mcand;
    logic [2*W-1:0]     r_acc;
    logic [W-1:0]       r_mplier;
    logic [CW-1:0]      r_count;
    logic [2*W-1:0]     w_acc_next;

    // Accumulator value after this step, so the final add lands directly in product.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = r_acc + r_mcand;
        end
    end

    always_ff @(posedge clk or negedge reset_asynchronous_n) begin
        if (!reset_asynchronous_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            product  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{W{1'b0}}, operand_a};
                        r_mplier <= operand_b;
                        r_acc    <= '0;
                        r_count  <= CW'(W);
                        r_state  <= S_RUN;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        product <= w_acc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier_seq
// Description : Scoreboard bench for shift_add_multiplier_seq (W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier_seq;

    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] prod;
        int             k;      // edge at which the operation is accepted
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     operand_a;
    logic [W-1:0]     operand_b;
    logic [2*W-1:0]   product;
    logic             busy;
    logic             done;

    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;
    exp_t             q[$];
    logic [2*W-1:0]   last_prod = '0;

    shift_add_multiplier_seq #(.W(W)) dut (
        .clk                  (clk),
        .reset_asynchronous_n (rst_n),
        .start                (start),
        .operand_a            (operand_a),
        .operand_b            (operand_b),
        .product              (product),
        .busy                 (busy),
        .done                 (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return (2*W)'(a) * (2*W)'(b);
    endfunction

    // Monitor: derives expected busy/done/product from the scoreboard head.
    always @(negedge clk) begin
        logic eb;
        logic ed;
        if (!rst_n) begin
            check("rst_product", 64'(product), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
        end else begin
            eb = (q.size() > 0) && (cyc >= q[0].k) && (cyc <= q[0].k + W - 1);
            ed = (q.size() > 0) && (cyc == q[0].k + W);
            check("busy", 64'(busy), 64'(eb));
            check("done", 64'(done), 64'(ed));
            if (ed) begin
                check("product", 64'(product), 64'(q[0].prod));
                last_prod = q[0].prod;
                void'(q.pop_front());
            end else begin
                check("product_hold", 64'(product), 64'(last_prod));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy%0d_done%0d required=idle cyc=%0d", busy, done, cyc);
        end
    endtask

    // Issue one operation; returns at the negedge right after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_idle();
        start     = 1'b1;
        operand_a = a;
        operand_b = b;
        e.prod    = ref_mul(a, b);
        e.k       = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        operand_a = W'($urandom);
        operand_b = W'($urandom);
    endtask

    initial begin
        exp_t e;
        int   k1;
        logic [W-1:0] a2;
        logic [W-1:0] b2;

        rst_n     = 1'b0;
        start     = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        do_op(4'd13, 4'd11);
        do_op(4'd15, 4'd15);
        do_op(4'd0, 4'd9);
        do_op(4'd9, 4'd0);

        // start and operand churn during RUN and DONE must be ignored
        do_op(4'd3, 4'd5);
        for (int i = 0; i <= W; i++) begin
            start     = 1'b1;
            operand_a = (i == 0) ? 4'd7 : W'($urandom);
            operand_b = (i == 0) ? 4'd7 : W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;

        // asynchronous abort in the second RUN cycle
        do_op(4'd6, 4'd6);
        @(posedge clk);
        @(posedge clk);
        #2;
        q.delete();
        last_prod = '0;
        rst_n = 1'b0;
        #1;
        check("async_product", 64'(product), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        do_op(4'd2, 4'd3);

        // back-to-back with start held high
        wait_idle();
        a2 = W'($urandom_range(1, 15));
        b2 = W'($urandom_range(1, 15));
        start     = 1'b1;
        operand_a = 4'd5;
        operand_b = 4'd5;
        k1        = cyc + 1;
        e.prod    = ref_mul(4'd5, 4'd5);
        e.k       = k1;
        q.push_back(e);
        @(negedge clk);
        operand_a = a2;
        operand_b = b2;
        e.prod    = ref_mul(a2, b2);
        e.k       = k1 + W + 2;
        q.push_back(e);
        repeat (W + 2) @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(W'($urandom), W'($urandom));
        end

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
